// File: rtl/reorder_buf.sv
// In-order retirement buffer: allocates ROB ids at dispatch, renames GPR operands,
// collects out-of-order writebacks and retires one instruction per cycle in program order.
module reorder_buf #(
    parameter int DATA      = 32,
    parameter int ADDR      = 32,
    parameter int ROB_DEPTH = 32,
    parameter int ROB       = $clog2(ROB_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            creg_exp_mask,
    input  logic [DATA-1:0] creg_tvec,
    input  logic            dec_e_,
    input  logic [ADDR-1:0] dec_pc,
    input  logic [6:0]      dec_rd,
    input  logic [6:0]      dec_rs1,
    input  logic [6:0]      dec_rs2,
    input  logic            dec_br_,
    input  logic            dec_br_pred_taken_,
    input  logic            dec_jump_,
    input  logic            dec_invalid,
    input  logic            wb_e_,
    input  logic [6:0]      wb_rd,
    input  logic [DATA-1:0] wb_data,
    input  logic            wb_exp_,
    input  logic [3:0]      wb_exp_code,
    input  logic            wb_pred_miss_,
    input  logic            wb_jump_miss_,
    output logic [ROB-1:0]  dec_rob_id,
    output logic [6:0]      ren_rs1,
    output logic [6:0]      ren_rs2,
    output logic [6:0]      ren_rd,
    output logic            commit_e_,
    output logic            flush_,
    output logic [ADDR-1:0] commit_pc,
    output logic [6:0]      commit_rd,
    output logic [DATA-1:0] commit_data,
    output logic [ROB-1:0]  commit_rob_id,
    output logic            commit_exp_,
    output logic [3:0]      commit_exp_code,
    output logic [ADDR-1:0] exp_handler_pc,
    output logic            rob_busy
);

    localparam logic [1:0] TYPE_GPR         = 2'd1;
    localparam logic [1:0] TYPE_ROB         = 2'd3;
    localparam logic [3:0] EXP_ILLEGAL_INST = 4'd2;
    localparam int         CNT              = ROB + 1;

    logic [ROB_DEPTH-1:0] ent_valid, ent_done, ent_br, ent_pred_taken, ent_jump;
    logic [ROB_DEPTH-1:0] ent_exp, ent_pred_miss, ent_jump_miss;
    logic [ADDR-1:0]      ent_pc       [ROB_DEPTH];
    logic [6:0]           ent_rd       [ROB_DEPTH];
    logic [3:0]           ent_exp_code [ROB_DEPTH];
    logic [DATA-1:0]      ent_data     [ROB_DEPTH];

    logic [31:0]          ren_valid;
    logic [ROB-1:0]       ren_id [32];

    // ROB_DEPTH is a power of two so head/tail wrap by plain overflow
    logic [ROB-1:0]       head, tail;
    logic [CNT-1:0]       count;

    logic                 full, do_disp, do_wb, do_commit, exp_hit, do_flush;
    logic [ROB-1:0]       wb_id;
    logic [4:0]           crd_addr;
    logic                 unused_sink;

    assign full      = (count == CNT'(ROB_DEPTH));
    assign do_disp   = ~dec_e_ & ~full;
    assign wb_id     = wb_rd[ROB-1:0];
    assign do_wb     = ~wb_e_ & ent_valid[wb_id];
    assign do_commit = ent_valid[head] & ent_done[head];
    assign exp_hit   = do_commit & ent_exp[head] & ~creg_exp_mask;
    assign do_flush  = exp_hit | (do_commit & (ent_pred_miss[head] | ent_jump_miss[head]));
    assign crd_addr  = ent_rd[head][4:0];

    assign dec_rob_id     = tail;
    assign ren_rd         = {TYPE_ROB, 5'(tail)};
    assign rob_busy       = full;
    assign exp_handler_pc = ADDR'(creg_tvec);
    assign unused_sink    = ^{wb_rd, ent_br, ent_pred_taken, ent_jump};

    always_comb begin
        ren_rs1 = dec_rs1;
        ren_rs2 = dec_rs2;
        if (dec_rs1[6:5] == TYPE_GPR && ren_valid[dec_rs1[4:0]])
            ren_rs1 = {TYPE_ROB, 5'(ren_id[dec_rs1[4:0]])};
        if (dec_rs2[6:5] == TYPE_GPR && ren_valid[dec_rs2[4:0]])
            ren_rs2 = {TYPE_ROB, 5'(ren_id[dec_rs2[4:0]])};
    end

    // Commit payload is zeroed when the head is not retiring
    always_comb begin
        commit_e_       = ~do_commit;
        flush_          = ~do_flush;
        commit_exp_     = ~exp_hit;
        commit_pc       = '0;
        commit_rd       = '0;
        commit_data     = '0;
        commit_rob_id   = '0;
        commit_exp_code = '0;
        if (do_commit) begin
            commit_pc       = ent_pc[head];
            commit_rd       = ent_rd[head];
            commit_data     = ent_data[head];
            commit_rob_id   = head;
            commit_exp_code = ent_exp_code[head];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid      <= '0;
            ent_done       <= '0;
            ent_br         <= '0;
            ent_pred_taken <= '0;
            ent_jump       <= '0;
            ent_exp        <= '0;
            ent_pred_miss  <= '0;
            ent_jump_miss  <= '0;
            ren_valid      <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_pc[i]       <= '0;
                ent_rd[i]       <= '0;
                ent_exp_code[i] <= '0;
                ent_data[i]     <= '0;
            end
            for (int i = 0; i < 32; i++)
                ren_id[i] <= '0;
        end else if (do_flush) begin
            ent_valid     <= '0;
            ent_done      <= '0;
            ent_exp       <= '0;
            ent_pred_miss <= '0;
            ent_jump_miss <= '0;
            ren_valid     <= '0;
            head          <= head + 1'b1;
            tail          <= head + 1'b1;
            count         <= '0;
        end else begin
            if (do_wb) begin
                ent_done[wb_id]      <= 1'b1;
                ent_data[wb_id]      <= wb_data;
                ent_exp[wb_id]       <= ~wb_exp_;
                ent_exp_code[wb_id]  <= wb_exp_code;
                ent_pred_miss[wb_id] <= ~wb_pred_miss_;
                ent_jump_miss[wb_id] <= ~wb_jump_miss_;
            end
            if (do_commit) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
                if (ent_rd[head][6:5] == TYPE_GPR && ren_id[crd_addr] == head)
                    ren_valid[crd_addr] <= 1'b0;
            end
            // Dispatch comes last so a same-rd rename beats the commit-clear above
            if (do_disp) begin
                ent_valid[tail]      <= 1'b1;
                ent_done[tail]       <= dec_invalid;
                ent_exp[tail]        <= dec_invalid;
                ent_exp_code[tail]   <= dec_invalid ? EXP_ILLEGAL_INST : 4'd0;
                ent_pred_miss[tail]  <= 1'b0;
                ent_jump_miss[tail]  <= 1'b0;
                ent_br[tail]         <= ~dec_br_;
                ent_pred_taken[tail] <= ~dec_br_pred_taken_;
                ent_jump[tail]       <= ~dec_jump_;
                ent_pc[tail]         <= dec_pc;
                ent_rd[tail]         <= dec_rd;
                ent_data[tail]       <= '0;
                tail                 <= tail + 1'b1;
                if (dec_rd[6:5] == TYPE_GPR && dec_rd[4:0] != 5'd0) begin
                    ren_valid[dec_rd[4:0]] <= 1'b1;
                    ren_id[dec_rd[4:0]]    <= tail;
                end
            end
            count <= count + CNT'(do_disp) - CNT'(do_commit);
        end
    end

endmodule

// File: tb/tb_reorder_buf.sv
// Scoreboard bench for reorder_buf: dispatched ids are queued in program order and
// every commit the DUT raises is popped and checked against a small per-entry model.
module tb_reorder_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        creg_exp_mask;
    logic [31:0] creg_tvec;
    logic        dec_e_;
    logic [31:0] dec_pc;
    logic [6:0]  dec_rd, dec_rs1, dec_rs2;
    logic        dec_br_, dec_br_pred_taken_, dec_jump_, dec_invalid;
    logic        wb_e_;
    logic [6:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exp_;
    logic [3:0]  wb_exp_code;
    logic        wb_pred_miss_, wb_jump_miss_;
    logic [4:0]  dec_rob_id, commit_rob_id;
    logic [6:0]  ren_rs1, ren_rs2, ren_rd, commit_rd;
    logic        commit_e_, flush_, commit_exp_, rob_busy;
    logic [31:0] commit_pc, commit_data, exp_handler_pc;
    logic [3:0]  commit_exp_code;

    reorder_buf dut (
        .clk(clk), .reset(reset), .creg_exp_mask(creg_exp_mask), .creg_tvec(creg_tvec),
        .dec_e_(dec_e_), .dec_pc(dec_pc), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_br_(dec_br_), .dec_br_pred_taken_(dec_br_pred_taken_), .dec_jump_(dec_jump_),
        .dec_invalid(dec_invalid), .wb_e_(wb_e_), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_exp_(wb_exp_), .wb_exp_code(wb_exp_code), .wb_pred_miss_(wb_pred_miss_),
        .wb_jump_miss_(wb_jump_miss_), .dec_rob_id(dec_rob_id), .ren_rs1(ren_rs1),
        .ren_rs2(ren_rs2), .ren_rd(ren_rd), .commit_e_(commit_e_), .flush_(flush_),
        .commit_pc(commit_pc), .commit_rd(commit_rd), .commit_data(commit_data),
        .commit_rob_id(commit_rob_id), .commit_exp_(commit_exp_),
        .commit_exp_code(commit_exp_code), .exp_handler_pc(exp_handler_pc), .rob_busy(rob_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [6:0]  rd;
        logic        exp;
        logic [3:0]  code;
        logic        pm;
        logic        jm;
        logic        inval;
    } mdl_t;

    mdl_t       mdl [32];
    int         sbq [$];
    logic [4:0] exp_tail;
    int         n_checks = 0;
    int         n_fail = 0;

    int         mon_id;
    logic       mon_exc, mon_fl, mon_exc_n, mon_fl_n;

    function automatic logic [6:0] gpr(input int n);
        return {2'b01, 5'(n)};
    endfunction
    function automatic logic [6:0] imm(input int n);
        return {2'b10, 5'(n)};
    endfunction
    function automatic logic [6:0] rob(input int n);
        return {2'b11, 5'(n)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Every DUT commit must match the oldest outstanding dispatch
    always @(negedge clk) begin
        if (!reset && !commit_e_) begin
            if (sbq.size() == 0) begin
                checkOutput("spurious_commit", commit_e_, 1);
            end else begin
                mon_id    = sbq.pop_front();
                mon_exc   = mdl[mon_id].exp & ~creg_exp_mask;
                mon_fl    = mon_exc | mdl[mon_id].pm | mdl[mon_id].jm;
                mon_exc_n = ~mon_exc;
                mon_fl_n  = ~mon_fl;
                checkOutput("commit_rob_id", commit_rob_id, mon_id);
                checkOutput("commit_pc", commit_pc, mdl[mon_id].pc);
                checkOutput("commit_rd", commit_rd, mdl[mon_id].rd);
                if (!mdl[mon_id].inval)
                    checkOutput("commit_data", commit_data, mdl[mon_id].data);
                checkOutput("commit_exp_", commit_exp_, mon_exc_n);
                checkOutput("commit_exp_code", commit_exp_code, mdl[mon_id].code);
                checkOutput("flush_", flush_, mon_fl_n);
                if (mon_fl) begin
                    sbq.delete();
                    exp_tail = 5'(mon_id + 1);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        sbq.delete();
        exp_tail = '0;
        @(posedge clk); #1;
        checkOutput("rst_commit_e_", commit_e_, 1);
        checkOutput("rst_flush_", flush_, 1);
        checkOutput("rst_commit_exp_", commit_exp_, 1);
        checkOutput("rst_rob_busy", rob_busy, 0);
        checkOutput("rst_dec_rob_id", dec_rob_id, 0);
        checkOutput("rst_commit_pc", commit_pc, 0);
        checkOutput("rst_commit_data", commit_data, 0);
        checkOutput("rst_commit_rob_id", commit_rob_id, 0);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [6:0] rd,
                                 input logic [6:0] rs1, input logic [6:0] rs2,
                                 input logic [6:0] x_rs1, input logic [6:0] x_rs2,
                                 input bit br, input bit jmp, input bit inval, input bit accept);
        logic [4:0] id;
        id = exp_tail;
        dec_e_ = 1'b0; dec_pc = pc; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_br_ = ~br; dec_br_pred_taken_ = ~br; dec_jump_ = ~jmp; dec_invalid = inval;
        #1;
        if (accept) begin
            checkOutput("dec_rob_id", dec_rob_id, id);
            checkOutput("ren_rd", ren_rd, rob(int'(id)));
        end else begin
            checkOutput("busy_on_reject", rob_busy, 1);
        end
        checkOutput("ren_rs1", ren_rs1, x_rs1);
        checkOutput("ren_rs2", ren_rs2, x_rs2);
        if (accept) begin
            mdl[id].pc = pc; mdl[id].data = '0; mdl[id].rd = rd;
            mdl[id].exp = inval; mdl[id].code = inval ? 4'd2 : 4'd0;
            mdl[id].pm = 1'b0; mdl[id].jm = 1'b0; mdl[id].inval = inval;
            sbq.push_back(int'(id));
            exp_tail = id + 1'b1;
        end
        @(posedge clk); #1;
        dec_e_ = 1'b1; dec_br_ = 1'b1; dec_br_pred_taken_ = 1'b1; dec_jump_ = 1'b1; dec_invalid = 1'b0;
    endtask

    task automatic writeback(input int id, input logic [31:0] data, input bit exc,
                             input logic [3:0] code, input bit pm, input bit jm);
        wb_e_ = 1'b0; wb_rd = rob(id); wb_data = data; wb_exp_ = ~exc; wb_exp_code = code;
        wb_pred_miss_ = ~pm; wb_jump_miss_ = ~jm;
        mdl[id].data = data; mdl[id].exp = exc; mdl[id].code = code;
        mdl[id].pm = pm; mdl[id].jm = jm;
        @(posedge clk); #1;
        wb_e_ = 1'b1; wb_exp_ = 1'b1; wb_pred_miss_ = 1'b1; wb_jump_miss_ = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    int         perm [8];
    int         tmp, j;
    logic [6:0] r_rd [8], r_rs1 [8], r_rs2 [8], r_x1 [8], r_x2 [8];

    initial begin
        reset = 1'b1; creg_exp_mask = 1'b0; creg_tvec = 32'h32bf8;
        dec_e_ = 1'b1; dec_pc = '0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0;
        dec_br_ = 1'b1; dec_br_pred_taken_ = 1'b1; dec_jump_ = 1'b1; dec_invalid = 1'b0;
        wb_e_ = 1'b1; wb_rd = '0; wb_data = '0; wb_exp_ = 1'b1; wb_exp_code = '0;
        wb_pred_miss_ = 1'b1; wb_jump_miss_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        $display("[TB] normal dispatch/writeback/commit");
        applyStimulus(32'hbeef0000, gpr(1), gpr(2), imm(3), gpr(2), imm(3), 0, 0, 0, 1);
        writeback(0, 32'haaaa, 0, 4'd0, 0, 0);
        checkOutput("commit_after_wb", commit_e_, 0);
        drain();

        $display("[TB] branch miss / hit, x0 rename");
        applyStimulus(32'hbeef0008, imm(0), imm(1), imm(2), imm(1), imm(2), 1, 0, 0, 1);
        writeback(1, 32'h1111, 0, 4'd0, 1, 0);
        drain();
        applyStimulus(32'hbeef000c, imm(0), imm(1), imm(2), imm(1), imm(2), 1, 0, 0, 1);
        writeback(2, 32'h2222, 0, 4'd0, 0, 0);
        drain();
        applyStimulus(32'hbeef0014, gpr(0), imm(1), imm(2), imm(1), imm(2), 0, 0, 0, 1);
        applyStimulus(32'hbeef0018, imm(0), gpr(0), gpr(0), gpr(0), gpr(0), 0, 0, 0, 1);
        writeback(4, 32'h4444, 0, 4'd0, 0, 0);
        writeback(3, 32'h3333, 0, 4'd0, 0, 0);
        drain();

        $display("[TB] jump miss");
        applyStimulus(32'hbeef0010, imm(0), imm(1), imm(2), imm(1), imm(2), 0, 1, 0, 1);
        writeback(5, 32'h5555, 0, 4'd0, 0, 1);
        drain();

        $display("[TB] exception, masked exception, illegal instruction");
        checkOutput("exp_handler_pc", exp_handler_pc, 32'h32bf8);
        applyStimulus(32'hbeef0020, imm(0), imm(1), imm(2), imm(1), imm(2), 0, 0, 0, 1);
        writeback(6, 32'h6666, 1, 4'd0, 0, 0);
        drain();
        creg_exp_mask = 1'b1;
        applyStimulus(32'hbeef0024, imm(0), imm(1), imm(2), imm(1), imm(2), 0, 0, 0, 1);
        writeback(7, 32'h7777, 1, 4'd0, 0, 0);
        drain();
        creg_exp_mask = 1'b0;
        applyStimulus(32'hbeef0028, gpr(9), imm(1), imm(2), imm(1), imm(2), 0, 0, 1, 1);
        checkOutput("illegal_commit_next", commit_e_, 0);
        drain();

        $display("[TB] dispatch renaming rd of committing instruction");
        applyStimulus(32'hbeef0030, gpr(3), imm(1), imm(2), imm(1), imm(2), 0, 0, 0, 1);
        writeback(9, 32'h9999, 0, 4'd0, 0, 0);
        applyStimulus(32'hbeef0034, gpr(3), imm(1), imm(2), imm(1), imm(2), 0, 0, 0, 1);
        applyStimulus(32'hbeef0038, imm(0), gpr(3), imm(2), rob(10), imm(2), 0, 0, 0, 1);
        writeback(11, 32'hbbbb, 0, 4'd0, 0, 0);
        writeback(10, 32'haaaa, 0, 4'd0, 0, 0);
        drain();

        $display("[TB] reorder");
        do_reset();
        r_rd[0] = gpr(1); r_rs1[0] = imm(1); r_rs2[0] = imm(2); r_x1[0] = imm(1);  r_x2[0] = imm(2);
        r_rd[1] = gpr(2); r_rs1[1] = gpr(1); r_rs2[1] = imm(2); r_x1[1] = rob(0);  r_x2[1] = imm(2);
        r_rd[2] = gpr(3); r_rs1[2] = gpr(1); r_rs2[2] = gpr(2); r_x1[2] = rob(0);  r_x2[2] = rob(1);
        r_rd[3] = gpr(4); r_rs1[3] = imm(4); r_rs2[3] = imm(5); r_x1[3] = imm(4);  r_x2[3] = imm(5);
        r_rd[4] = gpr(5); r_rs1[4] = imm(6); r_rs2[4] = imm(7); r_x1[4] = imm(6);  r_x2[4] = imm(7);
        r_rd[5] = gpr(4); r_rs1[5] = gpr(5); r_rs2[5] = imm(8); r_x1[5] = rob(4);  r_x2[5] = imm(8);
        r_rd[6] = gpr(2); r_rs1[6] = gpr(4); r_rs2[6] = imm(9); r_x1[6] = rob(5);  r_x2[6] = imm(9);
        r_rd[7] = gpr(7); r_rs1[7] = gpr(6); r_rs2[7] = gpr(2); r_x1[7] = gpr(6);  r_x2[7] = rob(6);
        for (int i = 0; i < 8; i++)
            applyStimulus(32'hcafe0000 + 32'(4 * i), r_rd[i], r_rs1[i], r_rs2[i], r_x1[i], r_x2[i], 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) perm[i] = i;
        for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < 8; i++)
            writeback(perm[i], $urandom, 0, 4'd0, 0, 0);
        drain();
        applyStimulus(32'hcafe0020, imm(0), gpr(2), gpr(7), gpr(2), gpr(7), 0, 0, 0, 1);

        $display("[TB] full buffer");
        do_reset();
        for (int i = 0; i < 32; i++)
            applyStimulus(32'hd0000000 + 32'(4 * i), imm(0), imm(1), imm(2), imm(1), imm(2), 0, 0, 0, 1);
        checkOutput("rob_busy_full", rob_busy, 1);
        applyStimulus(32'hd0000080, imm(0), imm(1), imm(2), imm(1), imm(2), 0, 0, 0, 0);
        writeback(0, 32'hf00d, 0, 4'd0, 0, 0);
        checkOutput("full_commit_visible", commit_e_, 0);
        @(posedge clk); #1;
        checkOutput("rob_busy_after_commit", rob_busy, 0);
        applyStimulus(32'hd0000084, imm(0), imm(1), imm(2), imm(1), imm(2), 0, 0, 0, 1);

        $display("[TB] reset mid-operation");
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
